uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmit serializer sitting directly downstream of the TX sync_fifo.
- Pops one byte at a time through the FIFO read interface.
- Frames each byte as start, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits, and drives the txd line.
- Bit period comes from a runtime clock divisor, so baud rate is software-programmable without re-synthesis.

Parameters:
- DATA_WIDTH, 8, width of FIFO data bus; frame always carries DATA_WIDTH data bits.
- DIV_WIDTH, 16, width of baud_div input and internal bit-period counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permit starting new frames; a frame in progress always completes.
- baud_div  input  DIV_WIDTH  clk cycles per bit; values 0 and 1 are treated as 2.
- parity_en  input  1  append a parity bit.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- two_stop  input  1  1 = two stop bits, 0 = one stop bit.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop strobe (combinational).
- fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- txd  output  1  serial line, idle high (registered).
- busy  output  1  high from the FETCH state until the frame ends.
- tx_done  output  1  single-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset values: state IDLE, txd=1, busy=0, tx_done=0, fifo_rd_en=0, all counters 0.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - fifo_rd_en = enable && !fifo_empty. Never asserted in any other state; exactly one pop per frame.
  - If fifo_rd_en is high, go to FETCH.
- FETCH (1 cycle):
  - Capture fifo_rd_data into the shift register.
  - Latch baud_div (clamped to >=2), parity_en, parity_odd and two_stop. Config changes mid-frame have no effect.
  - Compute parity = ^data XOR parity_odd.
  - Go to START.
- Bit timing: each of START, each DATA bit, PARITY and each STOP bit lasts exactly D latched cycles, using a down-counter loaded with D-1.
- txd by state: 0 in START, shift[0] in DATA (shift right after each bit), parity in PARITY, 1 in STOP and IDLE.
- Cycle timeline, with the pop in cycle 0:
  - FETCH in cycle 1.
  - txd falls at the start of cycle 2.
  - START occupies cycles 2..D+1.
  - DATA bit i occupies cycles 2+(i+1)D .. 1+(i+2)D.
- DATA to PARITY if parity is enabled, else to STOP. STOP lasts D or 2D cycles.
- tx_done is high in the last STOP cycle; the next cycle is IDLE.
- Back-to-back frames: a new pop may occur in that first IDLE cycle. Minimum inter-frame idle-high time is 2 cycles (IDLE + FETCH) beyond the stop bits.
- fifo_empty is sampled only in IDLE. A FIFO becoming non-empty mid-frame has no effect until IDLE.
- Deasserting enable mid-frame does not abort the frame. No further pops occur while enable is low.
- Async reset mid-frame: txd returns to 1 immediately and the frame is abandoned. The popped byte is lost, which is acceptable.
- Data counter is $clog2(DATA_WIDTH)+1 bits wide; the bit-period counter is DIV_WIDTH bits wide. No arithmetic overflow paths.

Decomposition:
- uart_pkg:
  - tx_state_e enum.
  - UART_DATA_WIDTH=8.
  - MIN_BAUD_DIV=2.
  - Parity helper function (shared with the future uart_rx).
- One sub-module: uart_bit_timer.
  - Loadable DIV_WIDTH down-counter.
  - Inputs load/period; output tick in the last cycle of each bit.
  - Reused by uart_rx.

Test Plan:
- D=4, no parity, 1 stop; FIFO holds 0xA5; enable=1 → fifo_rd_en pulses once in cycle 0; txd: 0 for cycles 2-5, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; tx_done in cycle 41.
- D=4, parity_en=1, parity_odd=0, data 0x07 → parity bit 1 appears after bit 7; parity_odd=1 gives 0; frame is 4 cycles longer.
- two_stop=1, FIFO holds 0x11 then 0x22 → stop is 8 cycles; second fifo_rd_en exactly 1 cycle after the first tx_done; txd high for stop+2 cycles between start bits.
- baud_div=0 → behaves as D=2 (full frame 20 cycles for 8N1 measured from START). Changing baud_div to 10 mid-frame leaves the current frame at D=2.
- enable dropped during DATA → frame completes with a correct tx_done pulse; no further fifo_rd_en despite fifo_empty=0; re-enable → pop next cycle.
- rst_n low during DATA → txd=1, busy=0 asynchronously; after release, stays IDLE with fifo_empty=1, and fifo_rd_en never asserts with fifo_empty=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive blocks.
//   UART_DATA_WIDTH : data bits carried per frame
//   MIN_BAUD_DIV    : smallest usable clk-cycles-per-bit; smaller divisors are clamped to it
//   tx_state_e      : transmit FSM state encoding
//   parity_bit()    : parity bit for a data word (even or odd)
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int MIN_BAUD_DIV    = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_FETCH  = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
  } tx_state_e;

  // Even parity makes the total count of ones even; odd inverts that bit.
  function automatic logic parity_bit(input logic [UART_DATA_WIDTH-1:0] data,
                                      input logic                       odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable down-counter that marks the last cycle of each bit period.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with period-1 (starts a new bit)
//   period     : clk cycles per bit, must be >= 1
//   tick       : high in the final cycle of the current bit
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  // Holds at zero once expired, so an idle timer keeps ticking harmlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= period - DIV_WIDTH'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer fed from a synchronous FIFO.
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : allow new frames to start (a running frame always completes)
//   baud_div      : clk cycles per bit, 0 and 1 behave as 2
//   parity_en     : append a parity bit
//   parity_odd    : 1 = odd parity, 0 = even parity
//   two_stop      : 1 = two stop bits, 0 = one
//   fifo_empty    : FIFO empty flag
//   fifo_rd_en    : FIFO pop strobe (combinational, IDLE only)
//   fifo_rd_data  : FIFO read data, valid the cycle after fifo_rd_en
//   txd           : serial output, idle high, registered
//   busy          : high from FETCH through the last stop cycle
//   tx_done       : one-cycle pulse in the final cycle of the last stop bit
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam logic [2:0] ST_IDLE   = TX_IDLE;
  localparam logic [2:0] ST_FETCH  = TX_FETCH;
  localparam logic [2:0] ST_START  = TX_START;
  localparam logic [2:0] ST_DATA   = TX_DATA;
  localparam logic [2:0] ST_PARITY = TX_PARITY;
  localparam logic [2:0] ST_STOP   = TX_STOP;

  localparam int                   BIT_CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] div);
    return (div < DIV_WIDTH'(MIN_BAUD_DIV)) ? DIV_WIDTH'(MIN_BAUD_DIV) : div;
  endfunction

  logic [2:0]            state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  stop_cnt;

  logic [DATA_WIDTH-1:0] shift;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  par_en_q;
  logic                  two_stop_q;
  logic                  parity_q;

  logic [DIV_WIDTH-1:0]  period;
  logic                  tick;
  logic                  load;
  logic                  in_bit;
  logic                  last_stop;

  // Pops happen only from IDLE; gating with rst_n keeps the strobe low while held in reset.
  assign fifo_rd_en = rst_n && (state == ST_IDLE) && enable && !fifo_empty;
  assign busy       = (state != ST_IDLE);

  assign in_bit    = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);
  assign last_stop = !two_stop_q || stop_cnt;
  assign tx_done   = (state == ST_STOP) && tick && last_stop;

  // FETCH starts the START bit timer from the live divisor, since div_q is
  // only being captured on that same edge; every later bit uses div_q.
  assign load   = (state == ST_FETCH) || (in_bit && tick);
  assign period = (state == ST_FETCH) ? clamp_div(baud_div) : div_q;

  uart_bit_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .period (period),
    .tick   (tick)
  );

  // Frame data and latched configuration: captured in FETCH, not reset.
  always_ff @(posedge clk) begin
    if (state == ST_FETCH) begin
      shift      <= fifo_rd_data;
      div_q      <= clamp_div(baud_div);
      par_en_q   <= parity_en;
      two_stop_q <= two_stop;
      parity_q   <= parity_bit(fifo_rd_data, parity_odd);
    end else if ((state == ST_DATA) && tick) begin
      shift <= shift >> 1;
    end
  end

  // Control FSM. txd is registered, so each branch drives the value for the
  // state being entered on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (fifo_rd_en) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state    <= ST_START;
          txd      <= 1'b0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            txd   <= shift[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                state <= ST_PARITY;
                txd   <= parity_q;
              end else begin
                state <= ST_STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              txd     <= shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            txd   <= 1'b1;
          end
        end
        ST_STOP: begin
          txd <= 1'b1;
          if (tick) begin
            if (last_stop) begin
              state <= ST_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
